// File: rtl/vproc_div_seq.sv
// Serial vector divide sequencer: one shared 32-bit restoring divider walks the elements of an operand word.
// Optional VPROC_DIV_SEQ_EARLY_EXIT_EN: iterate only eew bits and skip ITER for divide-by-zero/overflow elements.
module vproc_div_seq #(
    parameter int unsigned DIV_OP_W = 32
) (
    input  logic                    clk_i,
    input  logic                    async_rst_ni,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [1:0]              in_eew_i,
    input  logic                    in_rem_i,
    input  logic                    in_signed_i,
    input  logic [DIV_OP_W-1:0]     in_op1_i,
    input  logic [DIV_OP_W-1:0]     in_op2_i,
    input  logic [DIV_OP_W/8-1:0]   in_mask_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DIV_OP_W-1:0]     out_res_o,
    output logic [DIV_OP_W/8-1:0]   out_mask_o
);
    localparam int unsigned IDX_W = $clog2(DIV_OP_W / 8);
    localparam int unsigned MSK_W = DIV_OP_W / 8;

    typedef enum logic [2:0] {IDLE, SCAN, ITER, FIX, DONE} state_e;
    state_e state, state_nxt;

    logic [DIV_OP_W-1:0] op1, op2, res;
    logic [MSK_W-1:0]    mask;
    logic [1:0]          eew;
    logic                rem_sel, sgn;
    logic [IDX_W-1:0]    idx;
    logic [5:0]          cnt;
    logic [31:0]         quot, part, divisor;

    logic [5:0]  ew, n_iter;
    logic [31:0] ew_mask, sign_bit, elem_off, byte_idx;
    logic [31:0] a_raw, b_raw, a_ext, b_ext, mag_a, mag_b;
    logic [31:0] q_val, r_val, fix_val;
    logic [32:0] shifted, trial;
    logic        a_neg, b_neg, active, last, div0, ovf;

    // Element selection, sign handling and the per-cycle divider step.
    always_comb begin
        ew      = 6'd32;
        ew_mask = 32'hFFFF_FFFF;
        case (eew)
            2'b00:   begin ew = 6'd8;  ew_mask = 32'h0000_00FF; end
            2'b01:   begin ew = 6'd16; ew_mask = 32'h0000_FFFF; end
            default: ;
        endcase
        sign_bit = ew_mask ^ (ew_mask >> 1);
        elem_off = 32'(idx) * 32'(ew);
        byte_idx = elem_off >> 3;
        active   = |(mask & (MSK_W'(1) << byte_idx));
        last     = ((32'(idx) + 32'd1) * 32'(ew)) >= DIV_OP_W;
        a_raw    = 32'(op1 >> elem_off);
        b_raw    = 32'(op2 >> elem_off);
        a_ext    = (sgn && |(a_raw & sign_bit)) ? (a_raw | ~ew_mask) : (a_raw & ew_mask);
        b_ext    = (sgn && |(b_raw & sign_bit)) ? (b_raw | ~ew_mask) : (b_raw & ew_mask);
        a_neg    = sgn & a_ext[31];
        b_neg    = sgn & b_ext[31];
        mag_a    = a_neg ? -a_ext : a_ext;
        mag_b    = b_neg ? -b_ext : b_ext;
        div0     = (b_ext == 32'd0);
        ovf      = sgn && (a_ext == ~(ew_mask >> 1)) && (b_ext == 32'hFFFF_FFFF);
`ifdef VPROC_DIV_SEQ_EARLY_EXIT_EN
        n_iter   = ew;
`else
        n_iter   = 6'd32;
`endif
        shifted  = {part, quot[31]};
        trial    = shifted - {1'b0, divisor};
        q_val    = (a_neg ^ b_neg) ? -quot : quot;
        r_val    = a_neg ? -part : part;
        if (div0) begin
            q_val = 32'hFFFF_FFFF;
            r_val = a_ext;
        end else if (ovf) begin
            q_val = a_ext;
            r_val = 32'd0;
        end
        fix_val  = rem_sel ? r_val : q_val;
    end

    // State register.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) state <= IDLE;
        else               state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid_i) state_nxt = SCAN;
            SCAN: begin
                if (!active) begin
                    state_nxt = last ? DONE : SCAN;
                end else begin
`ifdef VPROC_DIV_SEQ_EARLY_EXIT_EN
                    state_nxt = (div0 || ovf) ? FIX : ITER;
`else
                    state_nxt = ITER;
`endif
                end
            end
            ITER: if (cnt == n_iter - 6'd1) state_nxt = FIX;
            FIX:  state_nxt = last ? DONE : SCAN;
            DONE: if (out_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        in_ready_o  = (state == IDLE);
        out_valid_o = (state == DONE);
    end

    // Datapath; the result word is cleared on capture so skipped elements need no write.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            op1 <= '0; op2 <= '0; res <= '0; mask <= '0;
            eew <= 2'b00; rem_sel <= 1'b0; sgn <= 1'b0;
            idx <= '0; cnt <= 6'd0;
            quot <= 32'd0; part <= 32'd0; divisor <= 32'd0;
        end else begin
            case (state)
                IDLE: if (in_valid_i) begin
                    op1     <= in_op1_i;
                    op2     <= in_op2_i;
                    mask    <= in_mask_i;
                    eew     <= in_eew_i;
                    rem_sel <= in_rem_i;
                    sgn     <= in_signed_i;
                    idx     <= '0;
                    res     <= '0;
                end
                SCAN: begin
                    if (!active) begin
                        if (!last) idx <= idx + IDX_W'(1);
                    end else begin
                        quot    <= mag_a << (6'd32 - n_iter);
                        part    <= 32'd0;
                        divisor <= mag_b;
                        cnt     <= 6'd0;
                    end
                end
                ITER: begin
                    quot <= {quot[30:0], ~trial[32]};
                    part <= trial[32] ? shifted[31:0] : trial[31:0];
                    cnt  <= cnt + 6'd1;
                end
                FIX: begin
                    res <= (res & ~(DIV_OP_W'(ew_mask) << elem_off))
                         | (DIV_OP_W'(fix_val & ew_mask) << elem_off);
                    if (!last) idx <= idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign out_res_o  = res;
    assign out_mask_o = mask;
endmodule

// File: tb/tb_vproc_div_seq.sv
// Self-checking bench for vproc_div_seq: behavioural element-wise divide model plus per-cycle compare process.
// Honours VPROC_DIV_SEQ_EARLY_EXIT_EN for the expected latencies.
module tb_vproc_div_seq;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_ready_o;
    logic [1:0]    in_eew = 2'b00;
    logic          in_rem = 1'b0, in_signed = 1'b0;
    logic [W-1:0]  in_op1 = '0, in_op2 = '0;
    logic [W/8-1:0] in_mask = '0;
    logic          out_valid_o, out_ready = 1'b0;
    logic [W-1:0]  out_res_o;
    logic [W/8-1:0] out_mask_o;

    int compared = 0;
    int mismatched = 0;

    // Model timeline owned by the compare process.
    bit          busy = 0;
    int          elapsed = 0;
    int          exp_cost = 0;
    logic [31:0] exp_res = '0;
    logic [3:0]  exp_mask = '0;

    vproc_div_seq #(.DIV_OP_W(W)) dut (
        .clk_i(clk), .async_rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready_o),
        .in_eew_i(in_eew), .in_rem_i(in_rem), .in_signed_i(in_signed),
        .in_op1_i(in_op1), .in_op2_i(in_op2), .in_mask_i(in_mask),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready),
        .out_res_o(out_res_o), .out_mask_o(out_mask_o)
    );

    always #5 clk = ~clk;

`ifdef VPROC_DIV_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Element-wise RISC-V divide with plain integer arithmetic.
    function automatic void model_word(input logic [1:0] eew, input logic rem, input logic sgn,
                                       input logic [31:0] op1, input logic [31:0] op2,
                                       input logic [3:0] mask, output logic [31:0] res,
                                       output int cost);
        int ew, n_iter, lo;
        longint a, b, q, r, v, lim;
        logic [31:0] mw;
        bit special;
        ew = (eew == 2'd0) ? 8 : (eew == 2'd1) ? 16 : 32;
        mw = (ew == 32) ? 32'hFFFF_FFFF : ((32'd1 << ew) - 32'd1);
        n_iter = EARLY ? ew : 32;
        lim = longint'(1) << ew;
        res = '0;
        cost = 0;
        for (int e = 0; e < 32 / ew; e++) begin
            lo = e * ew;
            if (!mask[lo / 8]) begin
                cost += 1;
                continue;
            end
            a = longint'((op1 >> lo) & mw);
            b = longint'((op2 >> lo) & mw);
            if (sgn && a >= lim / 2) a -= lim;
            if (sgn && b >= lim / 2) b -= lim;
            special = 1'b0;
            if (b == 0) begin
                q = -1; r = a; special = 1'b1;
            end else if (sgn && a == -(lim / 2) && b == -1) begin
                q = a; r = 0; special = 1'b1;
            end else begin
                q = a / b; r = a % b;
            end
            v = rem ? r : q;
            res |= 32'(v & longint'(mw)) << lo;
            cost += (EARLY && special) ? 2 : n_iter + 2;
        end
    endfunction

    // Checks DUT handshake and result against the model every cycle, then advances the model by one edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 0;
            check_output("reset_res", out_res_o, 32'd0);
            check_output("reset_mask", 32'(out_mask_o), 32'd0);
        end
        check_output("in_ready", 32'(in_ready_o), 32'(!busy));
        check_output("out_valid", 32'(out_valid_o), 32'(busy && elapsed >= exp_cost));
        if (busy && elapsed >= exp_cost) begin
            check_output("out_res", out_res_o, exp_res);
            check_output("out_mask", 32'(out_mask_o), 32'(exp_mask));
        end
        if (rst_n) begin
            if (!busy) begin
                if (in_valid) begin
                    model_word(in_eew, in_rem, in_signed, in_op1, in_op2, in_mask, exp_res, exp_cost);
                    exp_mask = in_mask;
                    busy = 1;
                    elapsed = 0;
                end
            end else if (elapsed >= exp_cost) begin
                if (out_ready) busy = 0;
            end else begin
                elapsed++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the output handshake.
    task automatic apply_stimulus(input logic [1:0] eew, input logic rem, input logic sgn,
                                  input logic [31:0] op1, input logic [31:0] op2,
                                  input logic [3:0] mask, input int hold, input bit keep,
                                  output logic [31:0] res, output logic [3:0] msk, output int lat);
        int guard;
        in_eew = eew; in_rem = rem; in_signed = sgn;
        in_op1 = op1; in_op2 = op2; in_mask = mask;
        in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!in_ready_o && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 50) begin
            compared++; mismatched++;
            $display("[TB] FAIL accept_timeout: got in_ready=0, expected 1");
        end
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!out_valid_o && lat < 400) begin
            lat++;
            @(negedge clk);
        end
        if (lat >= 400) begin
            compared++; mismatched++;
            $display("[TB] FAIL out_valid_timeout: got out_valid=0, expected 1");
        end
        res = out_res_o;
        msk = out_mask_o;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic reset_mid_word(input int k);
        int cnt;
        in_eew = 2'b00; in_rem = 1'b0; in_signed = 1'b1;
        in_op1 = 32'h1122_3344; in_op2 = 32'h0305_0709; in_mask = 4'hF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (cnt < k) begin
            cnt++;
            @(negedge clk);
        end
        #1 rst_n = 1'b0;
        #1;
        check_output("rst_in_ready", 32'(in_ready_o), 32'd1);
        check_output("rst_out_valid", 32'(out_valid_o), 32'd0);
        @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [31:0] r, op1, op2;
    logic [3:0]  m;
    int          lat, cost, hold, pick;
    logic [3:0]  bm;

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        model_word(2'b00, 1'b0, 1'b1, 32'h64F9_0780, 32'h0002_02FF, 4'hF, r, cost);
        check_output("model_t1_res", r, 32'hFFFD_0380);
        check_output("model_t1_cost", 32'(cost), EARLY ? 32'd24 : 32'd136);
        model_word(2'b00, 1'b1, 1'b1, 32'h64F9_0780, 32'h0002_02FF, 4'hF, r, cost);
        check_output("model_t2_res", r, 32'h64FF_0100);
        model_word(2'b01, 1'b0, 1'b0, 32'hFFFF_0064, 32'h0010_000A, 4'h3, r, cost);
        check_output("model_t3_res", r, 32'h0000_000A);
        check_output("model_t3_cost", 32'(cost), EARLY ? 32'd19 : 32'd35);
        model_word(2'b10, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0003, 4'hF, r, cost);
        check_output("model_t4_res", r, 32'h5555_5555);

        apply_stimulus(2'b00, 1'b0, 1'b1, 32'h64F9_0780, 32'h0002_02FF, 4'hF, 0, 1'b0, r, m, lat);
        check_output("t1_res", r, 32'hFFFD_0380);
        check_output("t1_lat", 32'(lat), EARLY ? 32'd24 : 32'd136);
        apply_stimulus(2'b00, 1'b1, 1'b1, 32'h64F9_0780, 32'h0002_02FF, 4'hF, 1, 1'b0, r, m, lat);
        check_output("t2_res", r, 32'h64FF_0100);
        check_output("t2_mask", 32'(m), 32'hF);
        apply_stimulus(2'b01, 1'b0, 1'b0, 32'hFFFF_0064, 32'h0010_000A, 4'h3, 0, 1'b0, r, m, lat);
        check_output("t3_res", r, 32'h0000_000A);
        check_output("t3_lat", 32'(lat), EARLY ? 32'd19 : 32'd35);
        apply_stimulus(2'b10, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0003, 4'hF, 5, 1'b1, r, m, lat);
        check_output("t4_res", r, 32'h5555_5555);
        check_output("t4_lat", 32'(lat), 32'd34);
        apply_stimulus(2'b10, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, r, m, lat);
        check_output("t5_ovf_rem", r, 32'd0);
        check_output("t5_ovf_lat", 32'(lat), EARLY ? 32'd2 : 32'd34);
        apply_stimulus(2'b10, 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0000, 4'hF, 0, 1'b0, r, m, lat);
        check_output("t5_div0_rem", r, 32'h8000_0000);

        reset_mid_word(EARLY ? 14 : 39);
        apply_stimulus(2'b00, 1'b0, 1'b1, 32'h64F9_0780, 32'h0002_02FF, 4'hF, 0, 1'b0, r, m, lat);
        check_output("t6_after_rst_res", r, 32'hFFFD_0380);

        for (int i = 0; i < 40; i++) begin
            op1  = $urandom;
            op2  = $urandom;
            pick = $urandom_range(0, 3);
            bm   = 4'($urandom_range(0, 15));
            case (pick)
                0: op2 &= {{8{bm[3]}}, {8{bm[2]}}, {8{bm[1]}}, {8{bm[0]}}};
                1: begin
                    op2 = 32'hFFFF_FFFF;
                    case (bm[1:0])
                        2'd0: op1 = 32'h8080_8080;
                        2'd1: op1 = 32'h8000_8000;
                        default: op1 = 32'h8000_0000;
                    endcase
                end
                2: op2 &= 32'h0F0F_0F0F;
                default: ;
            endcase
            hold = $urandom_range(0, 3);
            apply_stimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), op1, op2,
                           ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15)),
                           hold, 1'($urandom_range(0, 1)), r, m, lat);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
